ekey_mem_nway: RTL

EKEY_MEM_NWAY -- requirements
Module: ekey_mem_nway

---
 rtl/ekey_mem_nway.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ekey_mem_nway.sv
// N-way hash-bucket memories plus one value memory. Application ports get fixed
// two-cycle reads and always win; a word-wide PIO path does slow read-modify-writes.
`ifndef EKEY_HASH_TABLE_DEPTH_NBITS
`define EKEY_HASH_TABLE_DEPTH_NBITS 4
`endif
`ifndef EKEY_HASH_BUCKET_NBITS
`define EKEY_HASH_BUCKET_NBITS 80
`endif
`ifndef EKEY_VALUE_NBITS
`define EKEY_VALUE_NBITS 48
`endif
`ifndef EKEY_VALUE_DEPTH_NBITS
`define EKEY_VALUE_DEPTH_NBITS 4
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module ekey_mem_nway #(
    parameter int NUM_WAYS          = 2,
    parameter int DEPTH_NBITS       = `EKEY_HASH_TABLE_DEPTH_NBITS,
    parameter int BUCKET_NBITS      = `EKEY_HASH_BUCKET_NBITS,
    parameter int VALUE_NBITS       = `EKEY_VALUE_NBITS,
    parameter int VALUE_DEPTH_NBITS = `EKEY_VALUE_DEPTH_NBITS,
    parameter int PIO_NBITS         = 32
) (
    input  logic                             clk,
    input  logic                             `RESET_SIG,
    input  logic [`PIO_RANGE]                reg_addr,
    input  logic [PIO_NBITS-1:0]             reg_din,
    input  logic                             reg_rd,
    input  logic                             reg_wr,
    input  logic                             reg_ms_hash,
    input  logic                             reg_ms_value,
    output logic                             mem_ack,
    output logic [PIO_NBITS-1:0]             mem_rdata,
    output logic [7:0]                       err_cnt,
    input  logic [NUM_WAYS-1:0]              app_hash_rd,
    input  logic [NUM_WAYS*DEPTH_NBITS-1:0]  app_hash_raddr,
    output logic [NUM_WAYS-1:0]              app_hash_ack,
    output logic [NUM_WAYS*BUCKET_NBITS-1:0] app_hash_rdata,
    input  logic                             app_value_rd,
    input  logic [VALUE_DEPTH_NBITS-1:0]     app_value_raddr,
    output logic                             app_value_ack,
    output logic [VALUE_NBITS-1:0]           app_value_rdata,
    input  logic                             app_value_wr,
    input  logic [VALUE_DEPTH_NBITS-1:0]     app_value_waddr,
    input  logic [VALUE_NBITS-1:0]           app_value_wdata
);
    localparam int BW      = (BUCKET_NBITS + PIO_NBITS - 1) / PIO_NBITS;
    localparam int VW      = (VALUE_NBITS + PIO_NBITS - 1) / PIO_NBITS;
    localparam int MW      = (BW > VW) ? BW : VW;
    localparam int EW      = MW * PIO_NBITS;
    localparam int HWB     = (BW > 1) ? $clog2(BW) : 1;
    localparam int VWB     = (VW > 1) ? $clog2(VW) : 1;
    localparam int WAY_LSB = HWB + DEPTH_NBITS;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_RD = 3'd2,
                           S_CAP  = 3'd3, S_WR   = 3'd4, S_ACK = 3'd5;

    logic [2:0]                     state_q, state_d;
    logic [`PIO_RANGE]              pioAddr_q;
    logic [PIO_NBITS-1:0]           pioDin_q, memRdata_q;
    logic                           pioIsHash_q, pioIsWr_q;
    logic [EW-1:0]                  entry_q;
    logic [7:0]                     errCnt_q;

    logic                           pioStart, inOob, portBusy, pioIssue, pioWrite, valHazard;
    logic [1:0]                     pWay;
    logic [DEPTH_NBITS-1:0]         pHEntry;
    logic [VALUE_DEPTH_NBITS-1:0]   pVEntry;
    logic [31:0]                    curWord;
    logic                           wayAppRd;
    logic [BUCKET_NBITS-1:0]        wayRdData;
    logic [NUM_WAYS*BUCKET_NBITS-1:0] hRdFlat;
    logic [EW-1:0]                  capPad, mergedEntry;
    logic [PIO_NBITS-1:0]           capSlice;
    logic                           unusedBits;

    assign pioStart = (reg_rd | reg_wr) & (reg_ms_hash | reg_ms_value);
    assign inOob    = reg_ms_hash
                    ? ((32'(reg_addr[WAY_LSB +: 2]) >= 32'(NUM_WAYS)) || (32'(reg_addr[HWB-1:0]) >= 32'(BW)))
                    : (32'(reg_addr[VWB-1:0]) >= 32'(VW));

    assign pWay    = pioAddr_q[WAY_LSB +: 2];
    assign pHEntry = pioAddr_q[HWB +: DEPTH_NBITS];
    assign pVEntry = pioAddr_q[VWB +: VALUE_DEPTH_NBITS];
    assign curWord = pioIsHash_q ? 32'(pioAddr_q[HWB-1:0]) : 32'(pioAddr_q[VWB-1:0]);

    always_comb begin
        wayAppRd  = 1'b0;
        wayRdData = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (32'(pWay) == 32'(i)) begin
                wayAppRd  = app_hash_rd[i];
                wayRdData = hRdFlat[i*BUCKET_NBITS +: BUCKET_NBITS];
            end
        end
    end

    assign portBusy  = pioIsHash_q ? wayAppRd : app_value_rd;
    assign pioIssue  = (state_q == S_RD) && !portBusy;
    assign pioWrite  = (state_q == S_WR);
    // An app write landing on our latched value entry after its read makes the copy stale.
    assign valHazard = !pioIsHash_q && pioIsWr_q && app_value_wr && (app_value_waddr == pVEntry);

    logic [VALUE_NBITS-1:0] valRd_q;

    always_comb begin
        capPad = '0;
        if (pioIsHash_q) capPad[BUCKET_NBITS-1:0] = wayRdData;
        else             capPad[VALUE_NBITS-1:0]  = valRd_q;
        mergedEntry = capPad;
        capSlice    = '0;
        for (int w = 0; w < MW; w++) begin
            if (curWord == 32'(w)) begin
                capSlice = capPad[w*PIO_NBITS +: PIO_NBITS];
                mergedEntry[w*PIO_NBITS +: PIO_NBITS] = pioDin_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pioStart) state_d = inOob ? S_ACK : S_WAIT;
            S_WAIT: if (!portBusy) state_d = S_RD;
            S_RD:   if (!portBusy) state_d = S_CAP;
            S_CAP:  state_d = valHazard ? S_RD : (pioIsWr_q ? S_WR : S_ACK);
            S_WR:   if (valHazard) state_d = S_RD;
                    else if (pioIsHash_q || !app_value_wr) state_d = S_ACK;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG) begin
            state_q     <= S_IDLE;
            pioAddr_q   <= '0;
            pioDin_q    <= '0;
            pioIsHash_q <= 1'b0;
            pioIsWr_q   <= 1'b0;
            entry_q     <= '0;
            memRdata_q  <= '0;
            errCnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && pioStart) begin
                pioAddr_q   <= reg_addr;
                pioDin_q    <= reg_din;
                pioIsHash_q <= reg_ms_hash;
                pioIsWr_q   <= reg_wr;
                if (inOob) begin
                    memRdata_q <= '0;
                    if (errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
                end
            end
            if (state_q == S_CAP) begin
                entry_q <= mergedEntry;
                if (!pioIsWr_q) memRdata_q <= capSlice;
            end
        end
    end

    assign mem_ack   = (state_q == S_ACK);
    assign mem_rdata = memRdata_q;
    assign err_cnt   = errCnt_q;

    for (genvar i = 0; i < NUM_WAYS; i++) begin : gWay
        logic [BUCKET_NBITS-1:0] mem [2**DEPTH_NBITS];
        logic [BUCKET_NBITS-1:0] rd_q, rdata_q;
        logic [DEPTH_NBITS-1:0]  ra;
        logic                    re, we, valid_q, ack_q;

        assign ra = app_hash_rd[i] ? app_hash_raddr[i*DEPTH_NBITS +: DEPTH_NBITS] : pHEntry;
        assign re = app_hash_rd[i] | (pioIssue && pioIsHash_q && (32'(pWay) == 32'(i)));
        assign we = pioWrite && pioIsHash_q && (32'(pWay) == 32'(i));

        always_ff @(posedge clk) begin
            if (we) mem[pHEntry] <= entry_q[BUCKET_NBITS-1:0];
            if (re) rd_q <= (we && (pHEntry == ra)) ? entry_q[BUCKET_NBITS-1:0] : mem[ra];
        end

        always_ff @(posedge clk or posedge `RESET_SIG) begin
            if (`RESET_SIG) begin
                valid_q <= 1'b0;
                ack_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                valid_q <= app_hash_rd[i];
                ack_q   <= valid_q;
                if (valid_q) rdata_q <= rd_q;
            end
        end

        assign hRdFlat[i*BUCKET_NBITS +: BUCKET_NBITS]        = rd_q;
        assign app_hash_ack[i]                                = ack_q;
        assign app_hash_rdata[i*BUCKET_NBITS +: BUCKET_NBITS] = rdata_q;
    end

    // The value write port is shared; the app side always wins it.
    logic [VALUE_NBITS-1:0]       valMem [2**VALUE_DEPTH_NBITS];
    logic [VALUE_NBITS-1:0]       vWd, valRdata_q;
    logic [VALUE_DEPTH_NBITS-1:0] vWa, vRa;
    logic                         vWe, vRe, valValid_q, valAck_q;

    assign vWe = app_value_wr | (pioWrite && !pioIsHash_q);
    assign vWa = app_value_wr ? app_value_waddr : pVEntry;
    assign vWd = app_value_wr ? app_value_wdata : entry_q[VALUE_NBITS-1:0];
    assign vRa = app_value_rd ? app_value_raddr : pVEntry;
    assign vRe = app_value_rd | (pioIssue && !pioIsHash_q);

    always_ff @(posedge clk) begin
        if (vWe) valMem[vWa] <= vWd;
        if (vRe) valRd_q <= (vWe && (vWa == vRa)) ? vWd : valMem[vRa];
    end

    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG) begin
            valValid_q <= 1'b0;
            valAck_q   <= 1'b0;
            valRdata_q <= '0;
        end else begin
            valValid_q <= app_value_rd;
            valAck_q   <= valValid_q;
            if (valValid_q) valRdata_q <= valRd_q;
        end
    end

    assign app_value_ack   = valAck_q;
    assign app_value_rdata = valRdata_q;

    assign unusedBits = ^{pioAddr_q, entry_q, reg_addr};
endmodule
